// File: rtl/jk_excitation_driver.sv
// jk_excitation_driver
//   Drives an external bank of N J-K flip-flops toward a requested target word.
//   A target is taken over valid/ready. J/K for each bit comes from the J-K
//   excitation table applied to the bank's current Q. Q is read back after
//   SETTLE cycles. On a mismatch the block drives again, up to MAX_RETRY extra
//   times. Each request ends in either a done pulse or an err pulse.
//
// Ports
//   clk, rst           clock; asynchronous active-high reset
//   tgt_valid/ready    target handshake (ready only in IDLE)
//   tgt_data [N]       requested bank value
//   q_in     [N]       Q read back from the bank
//   j, k     [N]       excitation to the bank (nonzero only during DRIVE)
//   busy               request in progress
//   done / err         1-cycle completion pulses (mutually exclusive)
//   retry_cnt          retries used by the current/last request
module jk_excitation_driver #(
    parameter int N         = 4,
    parameter int SETTLE    = 1,
    parameter int MAX_RETRY = 2,
    parameter int DC_MODE   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tgt_valid,
    input  logic [N-1:0]         tgt_data,
    output logic                 tgt_ready,
    input  logic [N-1:0]         q_in,
    output logic [N-1:0]         j,
    output logic [N-1:0]         k,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [((MAX_RETRY > 0) ? $clog2(MAX_RETRY+1) : 1)-1:0] retry_cnt
);

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY+1) : 1;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic DC = (DC_MODE != 0);

    typedef enum logic [2:0] {
        S_IDLE, S_DRIVE, S_WAIT, S_CHECK, S_DONE, S_FAIL
    } state_t;

    state_t         state, state_d;
    logic [N-1:0]   tgt_q;
    logic [SW-1:0]  wait_cnt;
    logic           retry_inc;
    logic [N-1:0]   exc_tgt, jx, kx;

    // Excitation is computed on the cycle *before* DRIVE and registered, so
    // j/k are live exactly during the DRIVE cycle. This is safe because Q
    // cannot move during IDLE/CHECK: j=k=0 in those states.
    always_comb begin
        exc_tgt = (state == S_IDLE) ? tgt_data : tgt_q;
        jx      = '0;
        kx      = '0;
        for (int i = 0; i < N; i++) begin
            if (!q_in[i]) begin
                jx[i] = exc_tgt[i];
                kx[i] = DC;
            end else begin
                jx[i] = DC;
                kx[i] = ~exc_tgt[i];
            end
        end
    end

    always_comb begin
        state_d   = state;
        retry_inc = 1'b0;
        tgt_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        err       = 1'b0;
        case (state)
            S_IDLE: begin
                tgt_ready = 1'b1;
                busy      = 1'b0;
                if (tgt_valid) state_d = S_DRIVE;
            end
            S_DRIVE: state_d = S_WAIT;
            S_WAIT: begin
                if (wait_cnt == SW'(SETTLE-1)) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (q_in == tgt_q) begin
                    state_d = S_DONE;
                end else if (retry_cnt < RW'(MAX_RETRY)) begin
                    state_d   = S_DRIVE;
                    retry_inc = 1'b1;
                end else begin
                    state_d = S_FAIL;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_FAIL: begin
                err     = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            tgt_q     <= '0;
            retry_cnt <= '0;
            wait_cnt  <= '0;
            j         <= '0;
            k         <= '0;
        end else begin
            state <= state_d;
            if (state == S_IDLE && tgt_valid) begin
                tgt_q     <= tgt_data;
                retry_cnt <= '0;
            end else if (retry_inc) begin
                retry_cnt <= retry_cnt + RW'(1);
            end
            wait_cnt <= (state == S_WAIT) ? wait_cnt + SW'(1) : '0;
            if (state_d == S_DRIVE) begin
                j <= jx;
                k <= kx;
            end else begin
                j <= '0;
                k <= '0;
            end
        end
    end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench for jk_excitation_driver: two instances (DC_MODE 0 and 1), each with
// its own behavioural 4-bit J-K bank. Bank bit 0 can be stuck at 0.
module tb_jk_excitation_driver;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0] tv;
    logic [3:0] td [2];
    logic [1:0] trdy, busy, done, err;
    logic [3:0] j [2];
    logic [3:0] k [2];
    logic [1:0] rc [2];
    logic [3:0] bank [2];
    logic [1:0] ld, stuck;
    logic [3:0] ldv [2];

    int nchk = 0;
    int nerr = 0;

    jk_excitation_driver #(.N(4), .SETTLE(1), .MAX_RETRY(2), .DC_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .tgt_valid(tv[0]), .tgt_data(td[0]), .tgt_ready(trdy[0]),
        .q_in(bank[0]), .j(j[0]), .k(k[0]), .busy(busy[0]), .done(done[0]),
        .err(err[0]), .retry_cnt(rc[0]));

    jk_excitation_driver #(.N(4), .SETTLE(1), .MAX_RETRY(2), .DC_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .tgt_valid(tv[1]), .tgt_data(td[1]), .tgt_ready(trdy[1]),
        .q_in(bank[1]), .j(j[1]), .k(k[1]), .busy(busy[1]), .done(done[1]),
        .err(err[1]), .retry_cnt(rc[1]));

    // Behavioural J-K bank: 00 hold, 01 reset, 10 set, 11 toggle.
    always @(posedge clk) begin
        for (int b = 0; b < 2; b++) begin
            logic [3:0] nb;
            nb = bank[b];
            if (ld[b]) nb = ldv[b];
            else begin
                for (int i = 0; i < 4; i++) begin
                    case ({j[b][i], k[b][i]})
                        2'b01:   nb[i] = 1'b0;
                        2'b10:   nb[i] = 1'b1;
                        2'b11:   nb[i] = ~bank[b][i];
                        default: nb[i] = bank[b][i];
                    endcase
                end
            end
            if (stuck[b]) nb[0] = 1'b0;
            bank[b] <= nb;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int u, input logic [3:0] v);
        ld[u] = 1'b1; ldv[u] = v;
        tick;
        ld[u] = 1'b0;
    endtask

    // Returns one cycle into DRIVE.
    task automatic accept(input int u, input logic [3:0] t);
        tv[u] = 1'b1; td[u] = t;
        tick;
        tv[u] = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        load(0, 4'b0000);
        load(1, 4'b0000);
        nchk++; if (j[0] !== 4'b0 || k[0] !== 4'b0) begin nerr++; $display("FAIL rst_jk: got j=%b k=%b want 0000", j[0], k[0]); end
        nchk++; if (busy[0] !== 1'b0 || done[0] !== 1'b0 || err[0] !== 1'b0) begin nerr++; $display("FAIL rst_flags: got busy=%b done=%b err=%b want 0", busy[0], done[0], err[0]); end
        nchk++; if (rc[0] !== 2'd0) begin nerr++; $display("FAIL rst_rc: got %0d want 0", rc[0]); end
        rst = 1'b0;
        tick;
        nchk++; if (trdy[0] !== 1'b1) begin nerr++; $display("FAIL rst_ready: got %b want 1", trdy[0]); end
        // reset in the middle of a DRIVE cycle
        accept(0, 4'b1111);
        nchk++; if (j[0] !== 4'b1111) begin nerr++; $display("FAIL middrive_j: got %b want 1111", j[0]); end
        #2 rst = 1'b1;
        #1;
        nchk++; if (j[0] !== 4'b0 || k[0] !== 4'b0) begin nerr++; $display("FAIL midrst_jk: got j=%b k=%b want 0000", j[0], k[0]); end
        nchk++; if (busy[0] !== 1'b0 || done[0] !== 1'b0 || err[0] !== 1'b0) begin nerr++; $display("FAIL midrst_flags: got busy=%b done=%b err=%b want 0", busy[0], done[0], err[0]); end
        tick;
        rst = 1'b0;
        tick;
        nchk++; if (bank[0] !== 4'b0000) begin nerr++; $display("FAIL midrst_bank: got %b want 0000", bank[0]); end
        nchk++; if (trdy[0] !== 1'b1 || busy[0] !== 1'b0) begin nerr++; $display("FAIL midrst_idle: got ready=%b busy=%b want 1/0", trdy[0], busy[0]); end
    endtask

    task automatic test_basic;
        load(0, 4'b0000);
        accept(0, 4'b1010);
        nchk++; if (j[0] !== 4'b1010 || k[0] !== 4'b0000) begin nerr++; $display("FAIL basic_drive: got j=%b k=%b want 1010/0000", j[0], k[0]); end
        for (int c = 2; c <= 3; c++) begin
            tick;
            nchk++; if (done[0] !== 1'b0 || j[0] !== 4'b0 || k[0] !== 4'b0) begin nerr++; $display("FAIL basic_cyc%0d: got done=%b j=%b k=%b want 0", c, done[0], j[0], k[0]); end
        end
        tick;
        nchk++; if (done[0] !== 1'b1 || err[0] !== 1'b0) begin nerr++; $display("FAIL basic_done: got done=%b err=%b want 1/0", done[0], err[0]); end
        nchk++; if (bank[0] !== 4'b1010) begin nerr++; $display("FAIL basic_bank: got %b want 1010", bank[0]); end
        nchk++; if (rc[0] !== 2'd0) begin nerr++; $display("FAIL basic_rc: got %0d want 0", rc[0]); end
        tick;
        nchk++; if (done[0] !== 1'b0 || trdy[0] !== 1'b1) begin nerr++; $display("FAIL basic_after: got done=%b ready=%b want 0/1", done[0], trdy[0]); end
    endtask

    task automatic test_dc1;
        load(1, 4'b1100);
        accept(1, 4'b0110);
        // Per bit, MSB first: 1->0 J=1 K=1, 1->1 J=1 K=0, 0->1 J=1 K=1, 0->0 J=0 K=1
        nchk++; if (j[1] !== 4'b1110 || k[1] !== 4'b1011) begin nerr++; $display("FAIL dc1_drive: got j=%b k=%b want 1110/1011", j[1], k[1]); end
        tick; tick; tick;
        nchk++; if (done[1] !== 1'b1) begin nerr++; $display("FAIL dc1_done: got %b want 1", done[1]); end
        nchk++; if (bank[1] !== 4'b0110) begin nerr++; $display("FAIL dc1_bank: got %b want 0110", bank[1]); end
        tick;
    endtask

    task automatic test_stuck;
        int drives = 0;
        int errcyc = 0;
        bit sawdone = 0;
        stuck[0] = 1'b1;
        load(0, 4'b0000);
        accept(0, 4'b0001);
        for (int c = 1; c <= 20; c++) begin
            if (j[0] !== 4'b0 || k[0] !== 4'b0) drives++;
            if (done[0] === 1'b1) sawdone = 1;
            if (err[0] === 1'b1) begin errcyc = c; break; end
            tick;
        end
        nchk++; if (drives != 3) begin nerr++; $display("FAIL stuck_drives: got %0d want 3", drives); end
        nchk++; if (errcyc != 10) begin nerr++; $display("FAIL stuck_errcyc: got %0d want 10", errcyc); end
        nchk++; if (sawdone) begin nerr++; $display("FAIL stuck_nodone: got done pulse want none"); end
        nchk++; if (rc[0] !== 2'd2 || done[0] !== 1'b0) begin nerr++; $display("FAIL stuck_rc: got rc=%0d done=%b want 2/0", rc[0], done[0]); end
        tick;
        nchk++; if (rc[0] !== 2'd2 || trdy[0] !== 1'b1) begin nerr++; $display("FAIL stuck_hold: got rc=%0d ready=%b want 2/1", rc[0], trdy[0]); end
        stuck[0] = 1'b0;
    endtask

    task automatic test_back_to_back;
        load(0, 4'b0000);
        accept(0, 4'b0011);
        tv[0] = 1'b1; td[0] = 4'b1100;
        nchk++; if (j[0] !== 4'b0011 || k[0] !== 4'b0000) begin nerr++; $display("FAIL b2b_drive1: got j=%b k=%b want 0011/0000", j[0], k[0]); end
        for (int c = 1; c <= 4; c++) begin
            nchk++; if (trdy[0] !== 1'b0 || busy[0] !== 1'b1) begin nerr++; $display("FAIL b2b_busy%0d: got ready=%b busy=%b want 0/1", c, trdy[0], busy[0]); end
            if (c < 4) tick;
        end
        nchk++; if (done[0] !== 1'b1) begin nerr++; $display("FAIL b2b_done1: got %b want 1", done[0]); end
        tick;
        nchk++; if (trdy[0] !== 1'b1 || busy[0] !== 1'b0 || bank[0] !== 4'b0011) begin nerr++; $display("FAIL b2b_idle: got ready=%b busy=%b bank=%b want 1/0/0011", trdy[0], busy[0], bank[0]); end
        tick;
        tv[0] = 1'b0;
        nchk++; if (busy[0] !== 1'b1 || j[0] !== 4'b1100 || k[0] !== 4'b0011) begin nerr++; $display("FAIL b2b_drive2: got busy=%b j=%b k=%b want 1/1100/0011", busy[0], j[0], k[0]); end
        tick; tick; tick;
        nchk++; if (done[0] !== 1'b1 || bank[0] !== 4'b1100) begin nerr++; $display("FAIL b2b_done2: got done=%b bank=%b want 1/1100", done[0], bank[0]); end
        tick;
    endtask

    task automatic test_same;
        load(0, 4'b0101);
        accept(0, 4'b0101);
        nchk++; if (j[0] !== 4'b0000 || k[0] !== 4'b0000) begin nerr++; $display("FAIL same_drive: got j=%b k=%b want 0000/0000", j[0], k[0]); end
        for (int c = 2; c <= 5; c++) begin
            tick;
            nchk++; if ((j[0] & k[0]) !== 4'b0) begin nerr++; $display("FAIL same_jk%0d: got j&k=%b want 0000", c, j[0] & k[0]); end
            if (c == 4) begin
                nchk++; if (done[0] !== 1'b1 || bank[0] !== 4'b0101) begin nerr++; $display("FAIL same_done: got done=%b bank=%b want 1/0101", done[0], bank[0]); end
            end
        end
    endtask

    initial begin
        tv = '0; ld = '0; stuck = '0;
        td[0] = '0; td[1] = '0; ldv[0] = '0; ldv[1] = '0;
        test_reset;
        test_basic;
        test_dc1;
        test_stuck;
        test_back_to_back;
        test_same;
        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
